branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Direct-mapped branch target buffer with per-entry 2-bit saturating counters. It sits in the fetch stage and is the consumer of the resolved-branch control bus (is_taken, branch_target, i_addr) produced by the execute-stage branch unit. It is trained by resolved branches and answers one fetch-PC lookup per cycle with a registered taken/target prediction.

Parameters:
ENTRIES, 16, number of table entries; power of two, at least 2.
ADDR_WIDTH, 10, word-address width; matches core::ADDR_WIDTH. i_addr = pc[ADDR_WIDTH+1:2].
IDX_W, $clog2(ENTRIES), index width (derived).
TAG_W, ADDR_WIDTH-IDX_W, tag width (derived).

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
fetch_valid_i  in  1  lookup request this cycle
fetch_pc_i  in  32  byte PC being fetched
flush_i  in  1  pipeline flush/redirect from the branch unit
upd_valid_i  in  1  resolved conditional branch or jump is present on the update bus
upd_taken_i  in  1  resolved direction (br_bus is_taken)
upd_target_i  in  32  resolved target (br_bus branch_target)
upd_iaddr_i  in  ADDR_WIDTH  word address of the resolved branch (br_bus i_addr)
pred_valid_o  out  1  prediction on the outputs is valid
pred_taken_o  out  1  predicted taken
pred_target_o  out  32  predicted next PC
pred_pc_o  out  32  PC the prediction belongs to

Behaviour:
- Reset (rst_ni=0, asynchronous): all entry valid bits 0; counters 2'b01; tags and targets 0. All outputs 0. Reset mid-operation discards all training and any in-flight prediction.
- Lookup indexing: la = fetch_pc_i[ADDR_WIDTH+1:2]. Index = la[IDX_W-1:0]. Tag = la[ADDR_WIDTH-1:IDX_W]. fetch_pc_i[1:0] are ignored.
- Hit condition: the entry's valid bit is 1 and the stored tag equals the lookup tag.
- Latency: one cycle. Outputs are registered at the rising edge after the request.
- Edge with fetch_valid_i=1 and flush_i=0:
  - pred_valid_o <= 1.
  - pred_pc_o <= fetch_pc_i.
  - pred_taken_o <= hit & ctr[1].
  - pred_target_o <= stored target if predicted taken, otherwise fetch_pc_i + 4 (32-bit wrap).
- Edge with fetch_valid_i=0 and flush_i=0: pred_valid_o <= 0. The other outputs hold their values.
- flush_i=1 has priority over a lookup. At that edge pred_valid_o <= 0 and pred_taken_o <= 0, even if fetch_valid_i=1.
- Update indexing: the same index/tag split, applied to upd_iaddr_i. Updates are written at the rising edge.
- Update on a hit:
  - Counter saturates: taken increments, capped at 11; not-taken decrements, floored at 00.
  - If taken, the target is overwritten with upd_target_i.
- Update on a miss:
  - Taken allocates the entry, replacing any aliasing entry: valid=1, tag written, target=upd_target_i, counter=10 (weak taken).
  - Not-taken leaves the table unchanged; no allocation.
- flush_i does not block an update in the same cycle. The resolving branch that causes the flush must train the table.
- Simultaneous lookup and update to the same index: the lookup uses the pre-update (old) entry contents. There is no bypass; the update becomes visible from the next cycle's lookup.
- The counter state machine per entry has states SNT=00, WNT=01, WT=10, ST=11. Taken moves up one state and not-taken moves down one, saturating at both ends.
- Unallocated entries (valid=0) always predict not-taken.

Test Plan:
- Cold table: after reset, look up pc 0x40 -> next cycle pred_valid_o=1, pred_taken_o=0, pred_target_o=0x44, pred_pc_o=0x40.
- Allocate: update iaddr 0x10, taken, target 0x100; then look up 0x40 -> taken=1, target=0x100.
- Not-taken training after allocate:
  - One not-taken update of iaddr 0x10: counter 10->01, lookup 0x40 -> taken=0, target=0x44.
  - Second not-taken update: counter 01->00, lookup still not taken.
  - A not-taken update to an empty index leaves valid=0.
- Saturation: four taken updates of iaddr 0x10 leave the counter at 11; one not-taken update -> 10, lookup 0x40 still taken.
- Alias and flush:
  - Entry for 0x40 (index 0, tag 1) is allocated; look up 0x80 (index 0, tag 2) -> miss, taken=0, target=0x84.
  - A taken update of iaddr 0x20 replaces the entry; lookup 0x40 then misses.
  - fetch_valid_i=1 together with flush_i=1 -> pred_valid_o=0 next cycle.
- Same-cycle hazard and reset:
  - Lookup 0x40 in the same cycle as the first allocating update of iaddr 0x10 -> taken=0; the following lookup -> taken=1.
  - Assert rst_ni low mid-stream -> outputs 0 immediately; lookup 0x40 afterwards -> not taken.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Trained by resolved branches; answers one fetch-PC lookup per cycle, registered.

module bp_entry #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             taken,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic [31:0]      upd_target,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [1:0]       ctr,
    output logic [31:0]      target
);
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    logic       hit;
    logic [1:0] ctr_nxt;

    assign hit = valid && (tag == upd_tag);

    // Counter next state; a taken miss allocates at weak-taken.
    always_comb begin
        ctr_nxt = ctr;
        if (hit) begin
            if (taken) ctr_nxt = (ctr == ST)  ? ST  : ctr + 2'd1;
            else       ctr_nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
        end else if (taken) begin
            ctr_nxt = WT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            tag    <= '0;
            ctr    <= WNT;
            target <= '0;
        end else if (sel) begin
            if (hit || taken) ctr <= ctr_nxt;
            if (taken) begin
                valid  <= 1'b1;
                tag    <= upd_tag;
                target <= upd_target;
            end
        end
    end
endmodule

module branch_predictor #(
    parameter int ENTRIES    = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int IDX_W      = $clog2(ENTRIES),
    parameter int TAG_W      = ADDR_WIDTH - IDX_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fetch_valid_i,
    input  logic [31:0]           fetch_pc_i,
    input  logic                  flush_i,
    input  logic                  upd_valid_i,
    input  logic                  upd_taken_i,
    input  logic [31:0]           upd_target_i,
    input  logic [ADDR_WIDTH-1:0] upd_iaddr_i,
    output logic                  pred_valid_o,
    output logic                  pred_taken_o,
    output logic [31:0]           pred_target_o,
    output logic [31:0]           pred_pc_o
);
    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] target;
        logic [31:0] pc;
    } pred_t;

    logic [ENTRIES-1:0]            ent_valid;
    logic [ENTRIES-1:0][TAG_W-1:0] ent_tag;
    logic [ENTRIES-1:0][1:0]       ent_ctr;
    logic [ENTRIES-1:0][31:0]      ent_target;

    logic [ADDR_WIDTH-1:0] lk_addr;
    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_taken;
    logic [IDX_W-1:0]      upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    pred_t                 pred_q, pred_d;

    assign lk_addr = fetch_pc_i[ADDR_WIDTH+1:2];
    assign lk_idx  = lk_addr[IDX_W-1:0];
    assign lk_tag  = lk_addr[ADDR_WIDTH-1:IDX_W];
    assign upd_idx = upd_iaddr_i[IDX_W-1:0];
    assign upd_tag = upd_iaddr_i[ADDR_WIDTH-1:IDX_W];

    genvar e;
    generate
        for (e = 0; e < ENTRIES; e++) begin : g_entry
            bp_entry #(.TAG_W(TAG_W)) u_entry (
                .clk        (clk_i),
                .rst_n      (rst_ni),
                .sel        (upd_valid_i && (upd_idx == IDX_W'(e))),
                .taken      (upd_taken_i),
                .upd_tag    (upd_tag),
                .upd_target (upd_target_i),
                .valid      (ent_valid[e]),
                .tag        (ent_tag[e]),
                .ctr        (ent_ctr[e]),
                .target     (ent_target[e])
            );
        end
    endgenerate

    // Lookup reads pre-update table contents; no write-to-read bypass.
    assign lk_taken = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag)
                      && (ent_ctr[lk_idx] >= 2'b10);

    always_comb begin
        pred_d       = pred_q;
        pred_d.valid = 1'b0;
        if (flush_i) begin
            pred_d.taken = 1'b0;
        end else if (fetch_valid_i) begin
            pred_d.valid  = 1'b1;
            pred_d.taken  = lk_taken;
            pred_d.target = lk_taken ? ent_target[lk_idx] : fetch_pc_i + 32'd4;
            pred_d.pc     = fetch_pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pred_q <= '0;
        else         pred_q <= pred_d;
    end

    assign pred_valid_o  = pred_q.valid;
    assign pred_taken_o  = pred_q.taken;
    assign pred_target_o = pred_q.target;
    assign pred_pc_o     = pred_q.pc;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus pushes expected registered outputs from a table model,
// a monitor pops and compares one record per clock.

module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int AW      = 10;

    typedef struct {
        bit          v;
        bit          t;
        logic [31:0] tg;
        logic [31:0] pc;
    } exp_t;

    logic          clk, rst_n;
    logic          fetch_valid, flush, upd_valid, upd_taken;
    logic [31:0]   fetch_pc, upd_target;
    logic [AW-1:0] upd_iaddr;
    logic          pred_valid, pred_taken;
    logic [31:0]   pred_target, pred_pc;

    int vectors = 0;
    int miscompares = 0;

    // Reference table: plain arrays, counter kept as an integer 0..3.
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    exp_t        cur;
    exp_t        q[$];

    branch_predictor #(.ENTRIES(ENTRIES), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .fetch_valid_i(fetch_valid), .fetch_pc_i(fetch_pc), .flush_i(flush),
        .upd_valid_i(upd_valid), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_iaddr_i(upd_iaddr),
        .pred_valid_o(pred_valid), .pred_taken_o(pred_taken),
        .pred_target_o(pred_target), .pred_pc_o(pred_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        cur = '{v: 0, t: 0, tg: 0, pc: 0};
    endfunction

    task automatic cycle(input bit fv, input logic [31:0] pc, input bit fl,
                         input bit uv, input bit ut, input logic [31:0] utg,
                         input logic [AW-1:0] uia);
        int la, idx, tg, uidx, utag;
        bit tk;
        @(negedge clk);
        fetch_valid = fv; fetch_pc = pc; flush = fl;
        upd_valid = uv; upd_taken = ut; upd_target = utg; upd_iaddr = uia;
        la  = int'(pc[AW+1:2]);
        idx = la % ENTRIES;
        tg  = la / ENTRIES;
        if (fl) begin
            cur.v = 0; cur.t = 0;
        end else if (fv) begin
            tk     = m_valid[idx] && m_tag[idx] == tg && m_ctr[idx] >= 2;
            cur.v  = 1;
            cur.t  = tk;
            cur.tg = tk ? m_tgt[idx] : pc + 32'd4;
            cur.pc = pc;
        end else begin
            cur.v = 0;
        end
        q.push_back(cur);
        if (uv) begin
            uidx = int'(uia) % ENTRIES;
            utag = int'(uia) / ENTRIES;
            if (m_valid[uidx] && m_tag[uidx] == utag) begin
                if (ut) begin
                    m_ctr[uidx] = (m_ctr[uidx] < 3) ? m_ctr[uidx] + 1 : 3;
                    m_tgt[uidx] = utg;
                end else begin
                    m_ctr[uidx] = (m_ctr[uidx] > 0) ? m_ctr[uidx] - 1 : 0;
                end
            end else if (ut) begin
                m_valid[uidx] = 1; m_tag[uidx] = utag; m_tgt[uidx] = utg; m_ctr[uidx] = 2;
            end
        end
    endtask

    task automatic lookup(input logic [31:0] pc);
        cycle(1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic update(input bit t, input logic [31:0] tg, input logic [AW-1:0] ia);
        cycle(0, 0, 0, 1, t, tg, ia);
    endtask

    task automatic do_reset();
        @(negedge clk);
        fetch_valid = 0; flush = 0; upd_valid = 0; upd_taken = 0;
        fetch_pc = 0; upd_target = 0; upd_iaddr = 0;
        rst_n = 0;
        #1;
        vectors++;
        if ({pred_valid, pred_taken, pred_target, pred_pc} != '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%0d t=%0d tgt=%h pc=%h, expected all zero",
                     pred_valid, pred_taken, pred_target, pred_pc);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: one expected record per clock after the edge it was issued for.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                vectors++;
                if (pred_valid !== x.v || pred_taken !== x.t ||
                    (x.v && (pred_target !== x.tg || pred_pc !== x.pc))) begin
                    miscompares++;
                    $display("FAIL pred @%0t: got v=%0d t=%0d tgt=%h pc=%h, expected v=%0d t=%0d tgt=%h pc=%h",
                             $time, pred_valid, pred_taken, pred_target, pred_pc,
                             x.v, x.t, x.tg, x.pc);
                end
            end
        end
    end

    initial begin
        logic [31:0] pc, utg;
        logic [AW-1:0] ia;
        int waited;
        rst_n = 0;
        model_reset();
        do_reset();

        // Cold table, allocate, not-taken training
        lookup(32'h40);
        update(1, 32'h100, 10'h10);
        lookup(32'h40);
        update(0, 0, 10'h10);
        lookup(32'h40);
        update(0, 0, 10'h10);
        lookup(32'h40);
        update(0, 32'h55, 10'h05);
        lookup(32'h14);
        // Saturation then one step down
        repeat (4) update(1, 32'h100, 10'h10);
        update(0, 0, 10'h10);
        lookup(32'h40);
        // Alias and replacement
        lookup(32'h80);
        update(1, 32'h200, 10'h20);
        lookup(32'h40);
        lookup(32'h80);
        // Flush beats lookup; flushing branch still trains
        cycle(1, 32'h80, 1, 1, 1, 32'h300, 10'h30);
        lookup(32'hC0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        lookup(32'hFFFF_FFFC);
        // Mid-stream reset discards training
        do_reset();
        lookup(32'h40);
        lookup(32'h80);
        // Same-cycle lookup/update: old contents, then new
        cycle(1, 32'h40, 0, 1, 1, 32'h100, 10'h10);
        lookup(32'h41);

        for (int n = 0; n < 3000; n++) begin
            pc  = {$urandom} & 32'h0000_003F;
            pc  = {20'($urandom_range(0, 3) == 0 ? $urandom : 0),
                   $urandom_range(0, 3) == 0 ? 6'($urandom) : 6'($urandom_range(0, 3)),
                   4'($urandom), pc[1:0]};
            if ($urandom_range(0, 50) == 0) pc = 32'hFFFF_FFFC;
            ia  = {6'($urandom_range(0, 3)), 4'($urandom)};
            utg = $urandom;
            cycle($urandom_range(0, 3) != 0, pc, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, utg, ia);
            if (n == 1500) do_reset();
        end

        cycle(0, 0, 0, 0, 0, 0, 0);
        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending records, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
